// File: rtl/dma_pkg.sv
// Shared DMA definitions: FSM state encodings and default descriptor widths,
// reused by the channel arbiter and the move-engine FSM.
package dma_pkg;

  localparam int DMA_AW = 8;
  localparam int DMA_CW = 8;

  typedef logic [2:0] dma_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARB    = 3'd1;
  localparam logic [2:0] ST_LAUNCH = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RETIRE = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping modulo NCH. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [PW-1:0]  idx_o,
  output logic           valid_o
);

  localparam logic [PW:0] NCH_L = (PW+1)'(NCH);

  logic [PW:0] sum_s;
  logic [PW:0] cand_s;

  // Scan channels in rotated order and keep the first hit.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NCH; i++) begin
      sum_s  = {1'b0, ptr_i} + (PW+1)'(i);
      cand_s = (sum_s >= NCH_L) ? (sum_s - NCH_L) : sum_s;
      if (!valid_o && req_i[cand_s[PW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand_s[PW-1:0];
        gnt_o   = NCH'(1) << cand_s[PW-1:0];
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Shares one DMA move engine among NCH channels: round-robin grant, descriptor
// latch, launch, completion wait and sticky irq/err. Optional DMA_WATCHDOG_EN.
module dma_channel_arbiter
  import dma_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int AW     = DMA_AW,
  parameter int CW     = DMA_CW,
  parameter int WD_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*AW-1:0] src_i,
  input  logic [NCH*AW-1:0] dst_i,
  input  logic [NCH*CW-1:0] cnt_i,
  input  logic [NCH-1:0]    irq_clr,
  output logic [NCH-1:0]    gnt,
  output logic              dma_start,
  output logic [AW-1:0]     dma_src,
  output logic [AW-1:0]     dma_dst,
  output logic [CW-1:0]     dma_cnt,
  input  logic              dma_done,
  output logic [NCH-1:0]    irq,
  output logic [NCH-1:0]    err,
  output logic              busy
);

  localparam int PW = $clog2(NCH);

  dma_state_t     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  ch_q, ch_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic           start_q, start_d;
  logic [AW-1:0]  src_q, src_d;
  logic [AW-1:0]  dst_q, dst_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] irq_q, irq_d;
  logic [NCH-1:0] err_q, err_d;
  logic           busy_q, busy_d;
  logic [NCH-1:0] set_irq_s;
  logic [NCH-1:0] set_err_s;

  logic [NCH-1:0] arb_gnt_s;
  logic [PW-1:0]  arb_idx_s;
  logic           arb_valid_s;
  logic [CW-1:0]  arb_cnt_s;

`ifdef DMA_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(WD_CYC - 1);
  logic [7:0] wd_q, wd_d;
`endif

  rr_arbiter #(.NCH(NCH), .PW(PW)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt_s),
    .idx_o   (arb_idx_s),
    .valid_o (arb_valid_s)
  );

  assign arb_cnt_s = cnt_i[arb_idx_s*CW +: CW];

  // Next-state logic; the launch pulse is decided in ARB so it is registered.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    ch_d      = ch_q;
    gnt_d     = gnt_q;
    start_d   = 1'b0;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    set_irq_s = '0;
    set_err_s = '0;
`ifdef DMA_WATCHDOG_EN
    wd_d      = 8'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (arb_valid_s) begin
          state_d = ST_LAUNCH;
          gnt_d   = arb_gnt_s;
          ch_d    = arb_idx_s;
          src_d   = src_i[arb_idx_s*AW +: AW];
          dst_d   = dst_i[arb_idx_s*AW +: AW];
          cnt_d   = arb_cnt_s;
          start_d = (arb_cnt_s != '0);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      ST_LAUNCH: begin
        if (cnt_q == '0) begin
          state_d   = ST_RETIRE;
          set_irq_s = gnt_q;
          set_err_s = gnt_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dma_done) begin
          state_d   = ST_RETIRE;
          set_irq_s = gnt_q;
        end else begin
`ifdef DMA_WATCHDOG_EN
          if (wd_q == WD_LAST) begin
            state_d   = ST_RETIRE;
            set_irq_s = gnt_q;
            set_err_s = gnt_q;
          end else begin
            wd_d = wd_q + 8'd1;
          end
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_RETIRE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        ptr_d   = (ch_q == PW'(NCH-1)) ? '0 : (ch_q + 1'b1);
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    irq_d  = (irq_q & ~irq_clr) | set_irq_s;
    err_d  = (err_q & ~irq_clr) | set_err_s;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ch_q    <= '0;
      gnt_q   <= '0;
      start_q <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      irq_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      gnt_q   <= gnt_d;
      start_q <= start_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

`ifdef DMA_WATCHDOG_EN
  // Watchdog counter: counts WAIT cycles, cleared outside WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= 8'd0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  assign gnt       = gnt_q;
  assign dma_start = start_q;
  assign dma_src   = src_q;
  assign dma_dst   = dst_q;
  assign dma_cnt   = cnt_q;
  assign irq       = irq_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule
